// File: rtl/accum_pkg.sv
// Shared request and sequencer types for the shift-accumulate code RAM and its
// upstream frame sequencer.
package accum_pkg;

    typedef enum logic [1:0] {
        READ       = 2'd0,
        WRITE      = 2'd1,
        WRITE_OVER = 2'd2,
        DISABLE    = 2'd3
    } accum_request_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_SOF = 3'd1,
        CAPTURE  = 3'd2,
        DRAIN    = 3'd3,
        READOUT  = 3'd4
    } seq_state_t;

    localparam int unsigned DRAIN_CYCLES = 3;

    // Saturated pixels lock their address out; otherwise frame 0 overwrites.
    function automatic accum_request_t capture_request(input logic first_frame,
                                                       input logic saturated);
        accum_request_t req;
        if (saturated) begin
            req = DISABLE;
        end else if (first_frame) begin
            req = WRITE_OVER;
        end else begin
            req = WRITE;
        end
        return req;
    endfunction

endpackage

// File: rtl/pixel_index_counter.sv
// Index counter that saturates at DEPTH and flags whether the current index is
// a valid accumulator address. A clear with increment lands on 1.
module pixel_index_counter #(
    parameter  int DEPTH = 4096,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          clr_in,
    input  logic          inc_in,
    output logic [AW-1:0] count_out,
    output logic          in_range_out
);

    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0] count_r;

    // Index register: clear, saturating increment, or hold.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count_r <= {CW{1'b0}};
        end else if (clr_in) begin
            count_r <= inc_in ? CW'(1'b1) : {CW{1'b0}};
        end else if (inc_in && (count_r < DEPTH_C)) begin
            count_r <= count_r + CW'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count_out    = count_r[AW-1:0];
    assign in_range_out = (count_r < DEPTH_C);

endmodule

// File: rtl/accum_frame_sequencer.sv
// Capture/readout request sequencer for the shift-accumulate code RAM.
// Optional feature macro: ACCUM_SAT_DISABLE_EN (saturated pixels issue DISABLE).
module accum_frame_sequencer
    import accum_pkg::*;
#(
    parameter int DEPTH      = 4096,
    parameter int NUM_FRAMES = 8,
    parameter int LUMA_W     = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     start_in,
    input  logic                     abort_in,
    input  logic                     sof_in,
    input  logic                     pixel_valid_in,
    input  logic [LUMA_W-1:0]        luma_in,
    input  logic [LUMA_W-1:0]        on_thresh_in,
    input  logic [LUMA_W-1:0]        sat_thresh_in,
    input  logic                     readout_ready_in,
    output logic [$clog2(DEPTH)-1:0] addr_out,
    output logic                     summand_out,
    output accum_request_t           request_type_out,
    output logic                     request_valid_out,
    output logic                     busy_out,
    output logic                     done_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(NUM_FRAMES + 1);
    localparam logic [FW-1:0] LAST_FRAME = FW'(NUM_FRAMES - 1);
    localparam logic [1:0]    DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

    seq_state_t     state_r;
    logic [FW-1:0]  frame_r;
    logic [1:0]     drain_r;
    logic [AW-1:0]  addr_r;
    logic           summand_r;
    accum_request_t type_r;
    logic           valid_r;
    logic           busy_r;
    logic           done_r;

    logic [AW-1:0]  cnt_s;
    logic           cnt_in_range_s;
    logic           cnt_clr_s;
    logic           cnt_inc_s;
    logic           pix_sof_s;
    logic           pix_take_s;
    logic [AW-1:0]  pix_idx_s;
    logic           pix_in_range_s;
    logic           first_frame_s;
    logic           end_capture_s;
    logic           readout_go_s;
    logic           sat_s;

`ifdef ACCUM_SAT_DISABLE_EN
    assign sat_s = (luma_in >= sat_thresh_in);
`else
    logic unused_sat_s;
    assign sat_s        = 1'b0;
    assign unused_sat_s = ^sat_thresh_in;
`endif

    // Pixel qualification and shared index-counter control.
    always_comb begin
        pix_sof_s = sof_in && pixel_valid_in;
        case (state_r)
            WAIT_SOF: pix_take_s = pix_sof_s;
            CAPTURE:  pix_take_s = pixel_valid_in;
            default:  pix_take_s = 1'b0;
        endcase
        end_capture_s = (state_r == CAPTURE) && pix_sof_s && (frame_r == LAST_FRAME);
        if (pix_sof_s) begin
            pix_idx_s      = {AW{1'b0}};
            pix_in_range_s = 1'b1;
        end else begin
            pix_idx_s      = cnt_s;
            pix_in_range_s = cnt_in_range_s;
        end
        if (state_r == WAIT_SOF) begin
            first_frame_s = 1'b1;
        end else if (pix_sof_s) begin
            first_frame_s = 1'b0;
        end else begin
            first_frame_s = (frame_r == {FW{1'b0}});
        end
        readout_go_s = (state_r == READOUT) && readout_ready_in && cnt_in_range_s;
        cnt_clr_s    = !abort_in && ((pix_take_s && pix_sof_s) ||
                                     ((state_r == DRAIN) && (drain_r == DRAIN_LAST)));
        cnt_inc_s    = !abort_in && (pix_take_s || readout_go_s);
    end

    pixel_index_counter #(.DEPTH(DEPTH)) u_index (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .clr_in       (cnt_clr_s),
        .inc_in       (cnt_inc_s),
        .count_out    (cnt_s),
        .in_range_out (cnt_in_range_s)
    );

    // Sequencer FSM with registered request, busy and done outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r   <= IDLE;
            frame_r   <= {FW{1'b0}};
            drain_r   <= 2'd0;
            addr_r    <= {AW{1'b0}};
            summand_r <= 1'b0;
            type_r    <= READ;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else if (abort_in) begin
            state_r <= IDLE;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            done_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_in) begin
                        frame_r <= {FW{1'b0}};
                        state_r <= WAIT_SOF;
                        busy_r  <= 1'b1;
                    end
                end
                WAIT_SOF, CAPTURE: begin
                    if (end_capture_s) begin
                        state_r <= DRAIN;
                        drain_r <= 2'd0;
                    end else if (pix_take_s) begin
                        state_r <= CAPTURE;
                        if ((state_r == CAPTURE) && pix_sof_s) begin
                            frame_r <= frame_r + FW'(1'b1);
                        end
                        if (pix_in_range_s) begin
                            valid_r   <= 1'b1;
                            addr_r    <= pix_idx_s;
                            summand_r <= (luma_in > on_thresh_in);
                            type_r    <= capture_request(first_frame_s, sat_s);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_r == DRAIN_LAST) begin
                        state_r <= READOUT;
                    end else begin
                        drain_r <= drain_r + 2'd1;
                    end
                end
                READOUT: begin
                    if (cnt_in_range_s) begin
                        if (readout_ready_in) begin
                            valid_r   <= 1'b1;
                            addr_r    <= cnt_s;
                            summand_r <= 1'b0;
                            type_r    <= READ;
                        end
                    end else begin
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign addr_out          = addr_r;
    assign summand_out       = summand_r;
    assign request_type_out  = type_r;
    assign request_valid_out = valid_r;
    assign busy_out          = busy_r;
    assign done_out          = done_r;

endmodule

// File: tb/tb_accum_frame_sequencer.sv
// Randomised self-checking bench for accum_frame_sequencer against a request-list
// reference model built from the capture/readout rules.
`timescale 1ns/1ps
module tb_accum_frame_sequencer;
    import accum_pkg::*;

    localparam int DEPTH = 16;
    localparam int NF    = 4;
    localparam int AW    = 4;
`ifdef ACCUM_SAT_DISABLE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic          clk_in = 1'b0;
    logic          rst_n_in = 1'b0;
    logic          start_in = 1'b0;
    logic          abort_in = 1'b0;
    logic          sof_in = 1'b0;
    logic          pixel_valid_in = 1'b0;
    logic          readout_ready_in = 1'b0;
    logic [7:0]    luma_in = 8'd0;
    logic [7:0]    on_thresh_in = 8'd100;
    logic [7:0]    sat_thresh_in = 8'd250;
    logic [AW-1:0] addr_out;
    logic          summand_out;
    accum_request_t request_type_out;
    logic          request_valid_out;
    logic          busy_out;
    logic          done_out;

    typedef struct { int addr; int rtype; int summand; int cyc; } req_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    req_t mon_q[$];
    req_t exp_q[$];
    int   done_q[$];
    bit   rdy_hist [int];
    logic [7:0] lumas [NF][20];
    int   flen [NF];
    int   sof5_cyc;

    always #5 clk_in = ~clk_in;

    accum_frame_sequencer #(.DEPTH(DEPTH), .NUM_FRAMES(NF), .LUMA_W(8)) dut (
        .clk_in            (clk_in),
        .rst_n_in          (rst_n_in),
        .start_in          (start_in),
        .abort_in          (abort_in),
        .sof_in            (sof_in),
        .pixel_valid_in    (pixel_valid_in),
        .luma_in           (luma_in),
        .on_thresh_in      (on_thresh_in),
        .sat_thresh_in     (sat_thresh_in),
        .readout_ready_in  (readout_ready_in),
        .addr_out          (addr_out),
        .summand_out       (summand_out),
        .request_type_out  (request_type_out),
        .request_valid_out (request_valid_out),
        .busy_out          (busy_out),
        .done_out          (done_out)
    );

    // Cycle counter and ready history as seen by each rising edge.
    always @(posedge clk_in) begin
        rdy_hist[cyc] = readout_ready_in;
        cyc <= cyc + 1;
    end

    // Request and done logger, sampled mid-cycle.
    always @(negedge clk_in) begin
        if (request_valid_out === 1'b1)
            mon_q.push_back('{int'(addr_out), int'(request_type_out), int'(summand_out), cyc});
        if (done_out === 1'b1)
            done_q.push_back(cyc);
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pixel(input logic sof, input logic [7:0] luma);
        @(negedge clk_in);
        sof_in = sof;
        pixel_valid_in = 1'b1;
        luma_in = luma;
    endtask

    task automatic idle_cycle();
        @(negedge clk_in);
        sof_in = 1'b0;
        pixel_valid_in = 1'b0;
    endtask

    function automatic int model_type(input int f, input logic [7:0] l);
        if (SAT_EN && (l >= sat_thresh_in)) return 3;
        return (f == 0) ? 2 : 1;
    endfunction

    function automatic longint pack(input req_t r);
        return longint'(r.addr * 8 + r.rtype * 2 + r.summand);
    endfunction

    task automatic run_full(input int mode);
        int m0, n_cap, last_cap, first_rd, rd_idx, waited;
        int exp_rd[$];
        on_thresh_in = (mode == 0) ? 8'd100 : 8'($urandom_range(50, 200));
        for (int f = 0; f < NF; f++) begin
            flen[f] = (mode == 0) ? 16 : (mode == 1) ? 20 : int'($urandom_range(1, 20));
            for (int p = 0; p < 20; p++)
                lumas[f][p] = (mode == 0) ? ((p % 2 == 0) ? 8'd200 : 8'd10)
                                          : 8'($urandom_range(0, 255));
        end
        if (mode == 0) lumas[2][3] = 8'd255;
        exp_q.delete();
        for (int f = 0; f < NF; f++)
            for (int p = 0; p < flen[f]; p++)
                if (p < DEPTH)
                    exp_q.push_back('{p, model_type(f, lumas[f][p]),
                                      (lumas[f][p] > on_thresh_in) ? 1 : 0, 0});
        mon_q.delete();
        done_q.delete();
        @(negedge clk_in); start_in = 1'b1; readout_ready_in = 1'b1;
        @(negedge clk_in); start_in = 1'b0;
        check("busy_after_start", busy_out, 1);
        pixel(1'b0, 8'd255);
        pixel(1'b0, 8'd0);
        for (int f = 0; f < NF; f++) begin
            for (int p = 0; p < flen[f]; p++) begin
                if (mode != 0 && $urandom_range(0, 3) == 0) idle_cycle();
                pixel(p == 0, lumas[f][p]);
                start_in = (mode == 1 && f == 1 && p == 5);
                readout_ready_in = 1'($urandom);
            end
        end
        pixel(1'b1, 8'd0);
        start_in = 1'b0;
        readout_ready_in = 1'b1;
        sof5_cyc = cyc;
        m0 = sof5_cyc + 4;
        waited = 0;
        while (done_q.size() == 0 && waited < 300) begin
            @(negedge clk_in);
            pixel_valid_in = (mode == 2) ? 1'($urandom) : 1'b0;
            sof_in = pixel_valid_in & 1'($urandom);
            luma_in = 8'($urandom_range(0, 255));
            readout_ready_in = (mode == 0) ? !((cyc - m0) inside {[5:7]})
                                           : ($urandom_range(0, 3) != 0);
            waited++;
        end
        check("done_seen", done_q.size() > 0, 1);
        idle_cycle();
        readout_ready_in = 1'b0;
        repeat (3) idle_cycle();
        for (int m = m0; m < m0 + 400 && exp_rd.size() < DEPTH; m++)
            if (rdy_hist.exists(m) && rdy_hist[m]) exp_rd.push_back(m + 1);
        n_cap = 0; last_cap = -1; first_rd = -1; rd_idx = 0;
        foreach (mon_q[i]) begin
            if (mon_q[i].rtype != 0) begin
                if (n_cap < exp_q.size())
                    check($sformatf("m%0d_cap%0d", mode, n_cap), pack(mon_q[i]), pack(exp_q[n_cap]));
                n_cap++;
                last_cap = mon_q[i].cyc;
            end else begin
                if (first_rd < 0) first_rd = mon_q[i].cyc;
                if (rd_idx < exp_rd.size()) begin
                    check($sformatf("m%0d_rd_addr%0d", mode, rd_idx), mon_q[i].addr, rd_idx);
                    check($sformatf("m%0d_rd_cyc%0d", mode, rd_idx), mon_q[i].cyc, exp_rd[rd_idx]);
                end
                rd_idx++;
            end
        end
        check("cap_count", n_cap, exp_q.size());
        check("rd_count", rd_idx, DEPTH);
        check("drain_gap", (first_rd - last_cap) >= 4, 1);
        check("done_count", done_q.size(), 1);
        if (done_q.size() > 0 && exp_rd.size() == DEPTH)
            check("done_cyc", done_q[0], exp_rd[DEPTH-1] + 1);
        check("busy_idle", busy_out, 0);
    endtask

    initial begin
        int n_before;
        repeat (3) @(negedge clk_in);
        check("rst_addr", addr_out, 0);
        check("rst_summand", summand_out, 0);
        check("rst_type", request_type_out, 0);
        check("rst_valid", request_valid_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_done", done_out, 0);
        rst_n_in = 1'b1;
        repeat (2) @(negedge clk_in);

        run_full(0);
        run_full(1);
        run_full(2);

        // Abort on frame 1 pixel 7.
        exp_q.delete(); mon_q.delete(); done_q.delete();
        on_thresh_in = 8'd100;
        readout_ready_in = 1'b1;
        @(negedge clk_in); start_in = 1'b1;
        @(negedge clk_in); start_in = 1'b0;
        for (int f = 0; f < 2; f++) begin
            for (int p = 0; p < 16; p++) begin
                logic [7:0] l;
                l = 8'($urandom_range(0, 249));
                pixel(p == 0, l);
                if (f == 1 && p == 7) begin
                    abort_in = 1'b1;
                    break;
                end
                exp_q.push_back('{p, (f == 0) ? 2 : 1, (l > on_thresh_in) ? 1 : 0, 0});
            end
        end
        idle_cycle();
        abort_in = 1'b0;
        check("abort_busy", busy_out, 0);
        pixel(1'b1, 8'd200);
        for (int p = 1; p < 10; p++) pixel(1'b0, 8'd200);
        repeat (30) idle_cycle();
        check("abort_req_count", mon_q.size(), exp_q.size());
        foreach (mon_q[i])
            if (i < exp_q.size())
                check($sformatf("abort_req%0d", i), pack(mon_q[i]), pack(exp_q[i]));
        check("abort_no_done", done_q.size(), 0);

        run_full(2);

        // Asynchronous reset mid-frame.
        mon_q.delete();
        @(negedge clk_in); start_in = 1'b1;
        @(negedge clk_in); start_in = 1'b0;
        for (int p = 0; p < 6; p++) pixel(p == 0, 8'd200);
        #2 rst_n_in = 1'b0;
        start_in = 1'b1;
        #1;
        check("arst_addr", addr_out, 0);
        check("arst_summand", summand_out, 0);
        check("arst_type", request_type_out, 0);
        check("arst_valid", request_valid_out, 0);
        check("arst_busy", busy_out, 0);
        check("arst_done", done_out, 0);
        n_before = mon_q.size();
        check("arst_prior_reqs", n_before, 5);
        repeat (3) @(negedge clk_in);
        start_in = 1'b0;
        rst_n_in = 1'b1;
        pixel(1'b1, 8'd200);
        pixel(1'b0, 8'd200);
        repeat (4) idle_cycle();
        check("arst_start_ignored", busy_out, 0);
        check("arst_no_req", mon_q.size(), n_before);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/accum_frame_sequencer.md
# accum_frame_sequencer

Upstream request generator for the shift-accumulate code RAM. It thresholds a per-pixel luma stream over `NUM_FRAMES` camera frames and issues one accumulate request per pixel per frame, so each address builds an LED code bit by bit. After capture it drains the write pipeline, then sweeps every address with `READ` requests for the downstream decoder.

## Interface
Parameters:
- `DEPTH`, 4096: accumulator depth; pixel index ≥ `DEPTH` produces no request.
- `NUM_FRAMES`, 8: frames per capture; must be in 1..`WIDTH`-1 of the accumulator.
- `LUMA_W`, 8: luma width.

Ports:
- `clk_in`  in  1  clock.
- `rst_n_in`  in  1  reset, asynchronous, active-low.
- `start_in`  in  1  one-cycle pulse; begins capture from `IDLE`, ignored otherwise.
- `abort_in`  in  1  returns to `IDLE` from any state.
- `sof_in`  in  1  start of frame, coincident with the first pixel's `pixel_valid_in`.
- `pixel_valid_in`  in  1  luma valid.
- `luma_in`  in  `LUMA_W`  pixel luma.
- `on_thresh_in`  in  `LUMA_W`  summand = (`luma_in` > `on_thresh_in`).
- `sat_thresh_in`  in  `LUMA_W`  saturation threshold (see Configuration).
- `readout_ready_in`  in  1  downstream accepts a `READ` this cycle.
- `addr_out`  out  $clog2(DEPTH)  request address.
- `summand_out`  out  1  request summand bit.
- `request_type_out`  out  `accum_request_t`  `READ`=0, `WRITE`=1, `WRITE_OVER`=2, `DISABLE`=3.
- `request_valid_out`  out  1  request strobe.
- `busy_out`  out  1  high in every state except `IDLE`.
- `done_out`  out  1  one-cycle pulse when readout completes.

## Operation
- States: `IDLE` → `WAIT_SOF` → `CAPTURE` → `DRAIN` → `READOUT` → `IDLE`.
- `IDLE`: `start_in` clears the frame counter → `WAIT_SOF`.
- `WAIT_SOF`: pixels ignored. `sof_in`&&`pixel_valid_in` → `CAPTURE`; that pixel is processed as index 0.
- `CAPTURE`:
  - Pixel counter resets to 0 on `sof_in`, otherwise increments per valid pixel.
  - Each valid pixel with index < `DEPTH` issues one request at address = index.
  - Frame 0 uses `WRITE_OVER`; later frames use `WRITE`.
  - Summand = `luma_in` > `on_thresh_in`.
  - A `sof_in` after ≥1 pixel of the current frame increments the frame counter. When the counter reaches `NUM_FRAMES`, that pixel issues no request → `DRAIN`.
  - Short frames are allowed; unvisited addresses receive no request.
- `DRAIN`: exactly 3 cycles with no request, so the last write commits before any read → `READOUT`.
- `READOUT`:
  - Address counter starts at 0 and issues `READ` on each cycle `readout_ready_in`=1.
  - After `DEPTH`-1 is issued: `done_out` pulses next cycle → `IDLE`.
- `abort_in` has priority over all transitions: next state `IDLE`, no further requests, no `done_out`.
- `start_in` while busy is ignored.

## Timing
- Request outputs are registered. A pixel or ready at cycle t gives `request_valid_out` at t+1. Requests are issued back-to-back, at most one per cycle.
- `request_valid_out` is held high for exactly one cycle per request. Other request fields are held between requests.
- Reset values: `addr_out`=0, `summand_out`=0, `request_type_out`=`READ`, `request_valid_out`=0, `busy_out`=0, `done_out`=0; state `IDLE`.
- Reset mid-capture aborts immediately with no request pulse. Accumulator contents are undefined until the next full capture.
- Last `CAPTURE` request to first `READOUT` request: ≥4 cycles.

## Configuration
- `ACCUM_SAT_DISABLE_EN` defined: during `CAPTURE`, a pixel with `luma_in` ≥ `sat_thresh_in` issues `DISABLE` instead of `WRITE`/`WRITE_OVER`, including in frame 0. This locks out saturated ambient sources.
- Undefined: `sat_thresh_in` is unused and `DISABLE` is never issued.

## Structure
- `accum_pkg` holds:
  - `accum_request_t`;
  - the sequencer state enum `seq_state_t`;
  - the `DRAIN_CYCLES`=3 constant.
- Both this block and the accumulator import `accum_pkg`.
- One sub-module, `pixel_index_counter`: resettable, saturating at `DEPTH`, with an in-range flag. It is used for the capture pixel index and reused for the readout sweep.

## Test plan
- `DEPTH`=16, `NUM_FRAMES`=4, 16-pixel frames, luma alternating 200/10, `on_thresh_in`=100 → per frame 16 requests at addresses 0..15 with summands 1,0,1,0…; frame 0 is `WRITE_OVER`, frames 1–3 are `WRITE`.
- 20-pixel frames with `DEPTH`=16 → pixels 16–19 produce no request; each frame issues exactly 16 requests.
- After the 5th `sof_in` → 3 idle cycles, then `READ` at 0..15. Hold `readout_ready_in` low for cycles 5–7 → addresses stall and resume without gaps or repeats. `done_out` pulses once; `busy_out` falls.
- With `ACCUM_SAT_DISABLE_EN`, `sat_thresh_in`=250 and pixel 3 luma=255 in frame 2 → `DISABLE` at address 3 in frame 2 only.
- `abort_in` during frame 1 pixel 7 → no further requests, `busy_out`=0 next cycle, no `done_out`. A following `start_in` restarts with frame 0 `WRITE_OVER`.
- Assert `rst_n_in` low asynchronously mid-frame → all outputs reach reset values before the next edge; `start_in` ignored while `rst_n_in`=0.
